// File: rtl/hazard_control_if.sv
// Signal bundle between the pipeline datapath and the hazard/halt controller.
// The datapath side is the master; the controller is the slave.
interface hazard_control_if;
  logic [2:0]  rs_id;
  logic [2:0]  rd_id;
  logic        op_use_rs_id;
  logic        op_use_rd_id;
  logic        halt_id;
  logic        op_mem_read_ex;
  logic        op_reg_write_ex;
  logic [2:0]  write_addr_ex;
  logic        branch_taken_ex;
  logic        restart;
  logic        op_pc_write;
  logic        op_if_id_write;
  logic        op_if_id_flush;
  logic        op_id_ex_write;
  logic        halted;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  modport master (
    output rs_id, rd_id, op_use_rs_id, op_use_rd_id, halt_id,
           op_mem_read_ex, op_reg_write_ex, write_addr_ex,
           branch_taken_ex, restart,
    input  op_pc_write, op_if_id_write, op_if_id_flush, op_id_ex_write,
           halted, stall_count, flush_count
  );

  modport slave (
    input  rs_id, rd_id, op_use_rs_id, op_use_rd_id, halt_id,
           op_mem_read_ex, op_reg_write_ex, write_addr_ex,
           branch_taken_ex, restart,
    output op_pc_write, op_if_id_write, op_if_id_flush, op_id_ex_write,
           halted, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_control.sv
// Pipeline hazard/halt controller: load-use stall, branch flush, HLT drain.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush counters.
module hazard_control (
  input  logic      clock,
  input  logic      reset,
  hazard_control_if.slave hc
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] dc_q, dc_d;
  logic       halted_q;
  logic       lu_s;
  logic       pc_write_s, if_id_write_s, if_id_flush_s, id_ex_write_s;

  assign lu_s = hc.op_mem_read_ex & hc.op_reg_write_ex &
                ((hc.op_use_rs_id & (hc.rs_id == hc.write_addr_ex)) |
                 (hc.op_use_rd_id & (hc.rd_id == hc.write_addr_ex)));

  // State, drain counter and halted flag registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      dc_q     <= 2'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dc_q     <= dc_d;
      halted_q <= (state_d == ST_HALT);
    end
  end

  // Next-state and Mealy enable decode
  always_comb begin
    state_d       = state_q;
    dc_d          = dc_q;
    pc_write_s    = 1'b0;
    if_id_write_s = 1'b0;
    if_id_flush_s = 1'b0;
    id_ex_write_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hc.branch_taken_ex) begin
          // Anything in ID is in the branch shadow, so hazards and HLT there are moot
          pc_write_s    = 1'b1;
          if_id_write_s = 1'b1;
          if_id_flush_s = 1'b1;
        end else if (lu_s) begin
          pc_write_s    = 1'b0;
        end else if (hc.halt_id) begin
          if_id_write_s = 1'b1;
          if_id_flush_s = 1'b1;
          id_ex_write_s = 1'b1;
          state_d       = ST_DRAIN;
          dc_d          = 2'd0;
        end else begin
          pc_write_s    = 1'b1;
          if_id_write_s = 1'b1;
          id_ex_write_s = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (dc_q == 2'd2) begin
          state_d = ST_HALT;
          dc_d    = 2'd0;
        end else begin
          dc_d    = dc_q + 2'd1;
        end
      end
      ST_HALT: begin
        if (hc.restart) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_RUN;
        dc_d    = 2'd0;
      end
    endcase
  end

  // Enables are forced low for the whole time reset is held
  assign hc.op_pc_write    = pc_write_s    & reset;
  assign hc.op_if_id_write = if_id_write_s & reset;
  assign hc.op_if_id_flush = if_id_flush_s & reset;
  assign hc.op_id_ex_write = id_ex_write_s & reset;
  assign hc.halted         = halted_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_count_q, flush_count_q;
  logic        stall_inc_s, flush_inc_s;

  assign flush_inc_s = (state_q == ST_RUN) & hc.branch_taken_ex;
  assign stall_inc_s = (state_q == ST_RUN) & ~hc.branch_taken_ex & lu_s;

  // Saturating performance counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count_q <= 16'h0000;
      flush_count_q <= 16'h0000;
    end else begin
      if (stall_inc_s && (stall_count_q != 16'hFFFF)) begin
        stall_count_q <= stall_count_q + 16'h0001;
      end else begin
        stall_count_q <= stall_count_q;
      end
      if (flush_inc_s && (flush_count_q != 16'hFFFF)) begin
        flush_count_q <= flush_count_q + 16'h0001;
      end else begin
        flush_count_q <= flush_count_q;
      end
    end
  end

  assign hc.stall_count = stall_count_q;
  assign hc.flush_count = flush_count_q;
`else
  assign hc.stall_count = 16'h0000;
  assign hc.flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Randomized + directed bench for hazard_control against a behavioural model.
module tb_hazard_control;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  hazard_control_if hc ();

  hazard_control dut (
    .clock (clock),
    .reset (reset),
    .hc    (hc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode 0=running, 1=draining, 2=halted
  int m_mode       = 0;
  int m_drain_left = 0;
  int m_stall      = 0;
  int m_flush      = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int cnt_exp(input int v);
`ifdef HAZARD_PERF_CNT_EN
    return (v > 65535) ? 65535 : v;
`else
    return 0;
`endif
  endfunction

  function automatic bit model_lu();
    return hc.op_mem_read_ex && hc.op_reg_write_ex &&
           ((hc.op_use_rs_id && hc.rs_id == hc.write_addr_ex) ||
            (hc.op_use_rd_id && hc.rd_id == hc.write_addr_ex));
  endfunction

  task automatic drive(input logic [2:0] rs, input logic [2:0] rd, input logic urs,
                       input logic urd, input logic hlt, input logic mr, input logic rw,
                       input logic [2:0] wa, input logic br, input logic rst_p);
    hc.rs_id = rs; hc.rd_id = rd; hc.op_use_rs_id = urs; hc.op_use_rd_id = urd;
    hc.halt_id = hlt; hc.op_mem_read_ex = mr; hc.op_reg_write_ex = rw;
    hc.write_addr_ex = wa; hc.branch_taken_ex = br; hc.restart = rst_p;
  endtask

  task automatic drive_idle();
    drive(3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    m_mode = 0; m_drain_left = 0; m_stall = 0; m_flush = 0;
  endtask

  // One cycle: check outputs mid-cycle, then advance the model on the edge
  task automatic step();
    bit pc, ifw, fl, idex;
    @(negedge clock);
    pc = 0; ifw = 0; fl = 0; idex = 0;
    if (m_mode == 0) begin
      if (hc.branch_taken_ex) begin pc = 1; ifw = 1; fl = 1; end
      else if (model_lu()) begin end
      else if (hc.halt_id) begin ifw = 1; fl = 1; idex = 1; end
      else begin pc = 1; ifw = 1; idex = 1; end
    end
    check_eq("enables", {29'd0, hc.op_pc_write, hc.op_if_id_write, hc.op_id_ex_write},
             {29'd0, pc, ifw, idex});
    if (ifw) check_eq("if_id_flush", {31'd0, hc.op_if_id_flush}, {31'd0, fl});
    check_eq("halted", {31'd0, hc.halted}, {31'd0, (m_mode == 2)});
    check_eq("stall_count", {16'd0, hc.stall_count}, cnt_exp(m_stall));
    check_eq("flush_count", {16'd0, hc.flush_count}, cnt_exp(m_flush));
    @(posedge clock);
    case (m_mode)
      0: begin
        if (hc.branch_taken_ex) m_flush++;
        else if (model_lu()) m_stall++;
        else if (hc.halt_id) begin m_mode = 1; m_drain_left = 3; end
      end
      1: begin
        m_drain_left--;
        if (m_drain_left == 0) m_mode = 2;
      end
      default: if (hc.restart) m_mode = 0;
    endcase
    #1;
  endtask

  initial begin
    drive(3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    #3;
    check_eq("rst_enables", {28'd0, hc.op_pc_write, hc.op_if_id_write, hc.op_if_id_flush,
             hc.op_id_ex_write}, 32'd0);
    check_eq("rst_halted", {31'd0, hc.halted}, 32'd0);
    check_eq("rst_stall", {16'd0, hc.stall_count}, 32'd0);
    check_eq("rst_flush", {16'd0, hc.flush_count}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();

    // Load-use on rs, then recovery
    drive(3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    step();
    drive_idle();
    step();
    check_eq("stall_after_lu", {16'd0, hc.stall_count}, cnt_exp(1));
    // Same registers but operand not used: no stall
    drive(3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    step();
    // Load-use through rd
    drive(3'd0, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
    step();
    // Branch wins over load-use and HLT
    drive(3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
    step();
    drive_idle();
    step();
    check_eq("flush_after_br", {16'd0, hc.flush_count}, cnt_exp(1));
    check_eq("stall_after_br", {16'd0, hc.stall_count}, cnt_exp(2));

    // HLT: one issue cycle, three drain cycles, then hold in HALT
    drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step();
    drive(3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    check_eq("halted_after_4", {31'd0, hc.halted}, 32'd1);
    drive_idle();
    for (int i = 0; i < 4; i++) step();
    check_eq("halted_hold", {31'd0, hc.halted}, 32'd1);
    drive(3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    step();
    check_eq("halted_after_restart", {31'd0, hc.halted}, 32'd0);
    drive_idle();
    step();

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      drive(3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
            3'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0));
      step();
    end
    drive(3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step();

    // Asynchronous reset while draining with dc=1
    drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step();
    drive_idle();
    step();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_drain_en", {28'd0, hc.op_pc_write, hc.op_if_id_write, hc.op_if_id_flush,
             hc.op_id_ex_write}, 32'd0);
    check_eq("rst_drain_halted", {31'd0, hc.halted}, 32'd0);
    @(posedge clock); #1;
    check_eq("rst_held_en", {28'd0, hc.op_pc_write, hc.op_if_id_write, hc.op_if_id_flush,
             hc.op_id_ex_write}, 32'd0);
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("rel_pc_write", {31'd0, hc.op_pc_write}, 32'd1);
    check_eq("rel_halted", {31'd0, hc.halted}, 32'd0);
    step();

    // Counter saturation
    drive(3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) step();
    drive_idle();
    step();
    check_eq("stall_sat", {16'd0, hc.stall_count}, cnt_exp(65540));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
